// File: rtl/uart_rx_oversample.sv
// 8x-oversampling UART receiver with single-entry valid/ready holding register.
// Define UART_RX_PARITY_EN to expect an even-parity bit after the data byte.
module uart_rx_oversample #(
  parameter int CLK_FREQ = 100_000_000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] sel_baud,
  input  logic       rx,
  output logic [7:0] rx_data,
  input  logic       rx_ready,
  output logic       rx_valid,
  output logic       frame_err,
  output logic       overrun,
  output logic       parity_err,
  output logic       busy
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP,
    S_WAIT_HIGH
  } state_t;

  // Oversample divisors, one per baud selection code
  logic [15:0] div_table [4];

  for (genvar gi = 0; gi < 4; gi++) begin : g_div
    localparam int BAUD_RATE = (gi == 0) ? 9600  :
                               (gi == 1) ? 19200 :
                               (gi == 2) ? 57600 : 115200;
    localparam int DIV = CLK_FREQ / (BAUD_RATE * 8);
    assign div_table[gi] = 16'(DIV);
  end

  logic [1:0]  sync_reg;
  logic        line;
  state_t      state_reg;
  logic [15:0] div_reg;
  logic [15:0] cnt_reg;
  logic        tick;
  logic        start_det;
  logic        accept;
  logic [2:0]  tcnt_reg;
  logic [2:0]  bcnt_reg;
  logic [7:0]  shift_reg;
  logic [7:0]  rx_data_reg;
  logic        rx_valid_reg;
  logic        frame_err_reg;
  logic        overrun_reg;
  logic        parity_err_reg;
  logic        busy_reg;
`ifdef UART_RX_PARITY_EN
  logic        par_bit_reg;
`endif

  // Synchronizer resets to the idle level so reset release never fakes a start
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync_reg <= 2'b11;
    end else begin
      sync_reg <= {sync_reg[0], rx};
    end
  end

  assign line      = sync_reg[1];
  assign start_det = (state_reg == S_IDLE) && !line;
  assign tick      = (cnt_reg == div_reg - 16'd1);
  assign accept    = rx_valid_reg && rx_ready;

  // Oversample tick counter, phase-aligned to the detected start edge
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_reg <= 16'd0;
      div_reg <= 16'd0;
    end else if (start_det) begin
      cnt_reg <= 16'd0;
      div_reg <= div_table[sel_baud];
    end else if (state_reg == S_IDLE || tick) begin
      cnt_reg <= 16'd0;
    end else begin
      cnt_reg <= cnt_reg + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg      <= S_IDLE;
      tcnt_reg       <= 3'd0;
      bcnt_reg       <= 3'd0;
      shift_reg      <= 8'h00;
      rx_data_reg    <= 8'h00;
      rx_valid_reg   <= 1'b0;
      frame_err_reg  <= 1'b0;
      overrun_reg    <= 1'b0;
      parity_err_reg <= 1'b0;
      busy_reg       <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_bit_reg    <= 1'b0;
`endif
    end else begin
      frame_err_reg  <= 1'b0;
      parity_err_reg <= 1'b0;
      if (accept) begin
        rx_valid_reg <= 1'b0;
        overrun_reg  <= 1'b0;
      end

      case (state_reg)
        S_IDLE: begin
          if (!line) begin
            state_reg <= S_START;
            tcnt_reg  <= 3'd0;
            busy_reg  <= 1'b1;
          end
        end

        S_START: begin
          if (tick) begin
            if (tcnt_reg == 3'd3) begin
              tcnt_reg <= 3'd0;
              bcnt_reg <= 3'd0;
              if (!line) begin
                state_reg <= S_DATA;
              end else begin
                state_reg <= S_IDLE;
                busy_reg  <= 1'b0;
              end
            end else begin
              tcnt_reg <= tcnt_reg + 3'd1;
            end
          end
        end

        S_DATA: begin
          if (tick) begin
            tcnt_reg <= tcnt_reg + 3'd1;
            if (tcnt_reg == 3'd7) begin
              shift_reg <= {line, shift_reg[7:1]};
              bcnt_reg  <= bcnt_reg + 3'd1;
              if (bcnt_reg == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                state_reg <= S_PARITY;
`else
                state_reg <= S_STOP;
`endif
              end
            end
          end
        end

`ifdef UART_RX_PARITY_EN
        S_PARITY: begin
          if (tick) begin
            tcnt_reg <= tcnt_reg + 3'd1;
            if (tcnt_reg == 3'd7) begin
              par_bit_reg <= line;
              state_reg   <= S_STOP;
            end
          end
        end
`endif

        S_STOP: begin
          if (tick) begin
            tcnt_reg <= tcnt_reg + 3'd1;
            if (tcnt_reg == 3'd7) begin
              if (line) begin
                // A handshake on this same edge frees the register for the new byte
                if (!rx_valid_reg || accept) begin
                  rx_data_reg  <= shift_reg;
                  rx_valid_reg <= 1'b1;
                end else begin
                  overrun_reg <= 1'b1;
                end
`ifdef UART_RX_PARITY_EN
                parity_err_reg <= (^shift_reg) ^ par_bit_reg;
`endif
                state_reg <= S_IDLE;
                busy_reg  <= 1'b0;
              end else begin
                frame_err_reg <= 1'b1;
                state_reg     <= S_WAIT_HIGH;
              end
            end
          end
        end

        S_WAIT_HIGH: begin
          if (line) begin
            state_reg <= S_IDLE;
            busy_reg  <= 1'b0;
          end
        end

        default: begin
          state_reg <= S_IDLE;
          busy_reg  <= 1'b0;
        end
      endcase
    end
  end

  assign rx_data   = rx_data_reg;
  assign rx_valid  = rx_valid_reg;
  assign frame_err = frame_err_reg;
  assign overrun   = overrun_reg;
  assign busy      = busy_reg;
`ifdef UART_RX_PARITY_EN
  assign parity_err = parity_err_reg;
`else
  assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_oversample.sv
// Directed and randomized checks of uart_rx_oversample against a frame-level model.
// A 4 MHz clock keeps frame lengths short (divisors 52/26/8/4).
module tb_uart_rx_oversample;

  localparam int TB_CLK = 4_000_000;
`ifdef UART_RX_PARITY_EN
  localparam int STOP_TICKS = 84;
  localparam int PE_EXP     = 1;
`else
  localparam int STOP_TICKS = 76;
  localparam int PE_EXP     = 0;
`endif

  logic       clk = 1'b0;
  logic       reset;
  logic [1:0] sel_baud;
  logic       rx;
  logic [7:0] rx_data;
  logic       rx_ready;
  logic       rx_valid;
  logic       frame_err;
  logic       overrun;
  logic       parity_err;
  logic       busy;

  uart_rx_oversample #(.CLK_FREQ(TB_CLK)) dut (
    .clk        (clk),
    .reset      (reset),
    .sel_baud   (sel_baud),
    .rx         (rx),
    .rx_data    (rx_data),
    .rx_ready   (rx_ready),
    .rx_valid   (rx_valid),
    .frame_err  (frame_err),
    .overrun    (overrun),
    .parity_err (parity_err),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;
  int cyc    = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Observation state gathered on the falling edge
  int         rise_cyc;
  logic       rise_busy;
  int         busy_fall_cyc;
  int         fe_cnt = 0;
  int         pe_cnt = 0;
  bit         seen_busy;
  logic       prev_valid = 1'b0;
  logic       prev_busy  = 1'b0;
  logic [7:0] hs_q [$];
  int         frame_start;

  always @(negedge clk) begin
    if (rx_valid === 1'b1 && prev_valid !== 1'b1) begin
      rise_cyc  = cyc;
      rise_busy = busy;
    end
    prev_valid = rx_valid;
    if (busy === 1'b1) seen_busy = 1'b1;
    if (prev_busy === 1'b1 && busy === 1'b0) busy_fall_cyc = cyc;
    prev_busy = busy;
    if (frame_err === 1'b1) fe_cnt++;
    if (parity_err === 1'b1) pe_cnt++;
    if (rx_valid === 1'b1 && rx_ready === 1'b1) hs_q.push_back(rx_data);
  end

  function automatic int div_of(input logic [1:0] s);
    case (s)
      2'd0:    return TB_CLK / (9600 * 8);
      2'd1:    return TB_CLK / (19200 * 8);
      2'd2:    return TB_CLK / (57600 * 8);
      default: return TB_CLK / (115200 * 8);
    endcase
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clocks(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Drives one frame; a bad stop bit leaves the line low on return
  task automatic send_frame(input logic [7:0] d, input logic [1:0] sel,
                            input bit bad_stop, input bit bad_par, input bit scramble);
    int bitp;
    bitp = 8 * div_of(sel);
    sel_baud = sel;
    @(posedge clk); #1;
    frame_start = cyc;
    rx = 1'b0;
    clocks(bitp);
    if (scramble) sel_baud = 2'($urandom);
    for (int i = 0; i < 8; i++) begin
      rx = d[i];
      clocks(bitp);
    end
`ifdef UART_RX_PARITY_EN
    rx = (^d) ^ bad_par;
    clocks(bitp);
`endif
    rx = !bad_stop;
    clocks(bitp);
  endtask

  logic [7:0] exp_q [$];
  logic [7:0] hs0, hs1, byte_v;
  int         fe0, pe0, exp_fe, bitp, t0, gap;
  bit         bad;
  logic [1:0] sel_r;

  initial begin
    reset    = 1'b0;
    rx       = 1'b1;
    sel_baud = 2'd3;
    rx_ready = 1'b0;
    clocks(5);
    check("reset_rx_data",    32'(rx_data),    32'h00);
    check("reset_rx_valid",   32'(rx_valid),   32'h0);
    check("reset_frame_err",  32'(frame_err),  32'h0);
    check("reset_overrun",    32'(overrun),    32'h0);
    check("reset_parity_err", 32'(parity_err), 32'h0);
    check("reset_busy",       32'(busy),       32'h0);
    reset = 1'b1;
    clocks(5);

    // Single byte, latency from falling edge = 2 sync + 1 detect + stop ticks
    rise_cyc = -1;
    send_frame(8'hA5, 2'd3, 1'b0, 1'b0, 1'b0);
    check("t1_latency",   32'(rise_cyc - frame_start), 32'(STOP_TICKS * div_of(2'd3) + 3));
    check("t1_busy_at_valid", 32'(rise_busy), 32'h0);
    check("t1_rx_data",   32'(rx_data),  32'hA5);
    check("t1_rx_valid",  32'(rx_valid), 32'h1);
    rx_ready = 1'b1;
    clocks(1);
    rx_ready = 1'b0;
    clocks(1);
    check("t1_valid_cleared", 32'(rx_valid), 32'h0);

    // Back-to-back frames at the slowest rate with the consumer always ready
    hs_q.delete();
    rx_ready = 1'b1;
    send_frame(8'h3C, 2'd0, 1'b0, 1'b0, 1'b0);
    send_frame(8'hC3, 2'd0, 1'b0, 1'b0, 1'b0);
    clocks(8 * div_of(2'd0));
    hs0 = (hs_q.size() > 0) ? hs_q[0] : 8'hxx;
    hs1 = (hs_q.size() > 1) ? hs_q[1] : 8'hxx;
    check("t2_hs_count",  32'(hs_q.size()), 32'd2);
    check("t2_first",     32'(hs0), 32'h3C);
    check("t2_second",    32'(hs1), 32'h C3);
    check("t2_overrun",   32'(overrun), 32'h0);

    // Overrun: second byte discarded while the first is still held
    rx_ready = 1'b0;
    send_frame(8'h11, 2'd2, 1'b0, 1'b0, 1'b0);
    send_frame(8'h22, 2'd2, 1'b0, 1'b0, 1'b0);
    clocks(4);
    check("t3_rx_data",   32'(rx_data),  32'h11);
    check("t3_rx_valid",  32'(rx_valid), 32'h1);
    check("t3_overrun",   32'(overrun),  32'h1);
    rx_ready = 1'b1;
    clocks(1);
    rx_ready = 1'b0;
    clocks(1);
    check("t3_valid_after_hs",   32'(rx_valid), 32'h0);
    check("t3_overrun_after_hs", 32'(overrun),  32'h0);

    // Start glitch two ticks long is rejected at the 4th tick
    sel_baud  = 2'd2;
    fe0       = fe_cnt;
    seen_busy = 1'b0;
    busy_fall_cyc = -1;
    @(posedge clk); #1;
    t0 = cyc;
    rx = 1'b0;
    clocks(2 * div_of(2'd2));
    rx = 1'b1;
    clocks(6 * div_of(2'd2));
    check("t4_seen_busy",  32'(seen_busy), 32'h1);
    check("t4_busy_fall",  32'(busy_fall_cyc - t0), 32'(3 + 4 * div_of(2'd2)));
    check("t4_busy",       32'(busy),      32'h0);
    check("t4_rx_valid",   32'(rx_valid),  32'h0);
    check("t4_no_frame_err", 32'(fe_cnt - fe0), 32'd0);

    // Framing error followed by a long break
    bitp = 8 * div_of(2'd2);
    fe0  = fe_cnt;
    send_frame(8'h55, 2'd2, 1'b1, 1'b0, 1'b0);
    clocks(20 * bitp);
    check("t5_one_frame_err", 32'(fe_cnt - fe0), 32'd1);
    check("t5_rx_valid",      32'(rx_valid), 32'h0);
    check("t5_busy_in_break", 32'(busy),     32'h1);
    rx = 1'b1;
    clocks(bitp);
    check("t5_idle_after_break", 32'(busy), 32'h0);

    // Reset in the middle of a 0xFF frame, then a clean 0x81
    hs_q.delete();
    rx_ready = 1'b1;
    pe0      = pe_cnt;
    sel_baud = 2'd2;
    @(posedge clk); #1;
    rx = 1'b0;
    clocks(bitp);
    rx = 1'b1;
    clocks(3 * bitp);
    check("t6_busy_mid_data", 32'(busy), 32'h1);
    reset = 1'b0;
    clocks(2);
    check("t6_busy_in_reset",  32'(busy),     32'h0);
    check("t6_valid_in_reset", 32'(rx_valid), 32'h0);
    reset = 1'b1;
    clocks(bitp);
    send_frame(8'h81, 2'd2, 1'b0, 1'b1, 1'b0);
    clocks(10);
    hs0 = (hs_q.size() > 0) ? hs_q[0] : 8'hxx;
    check("t6_hs_count",   32'(hs_q.size()),   32'd1);
    check("t6_hs_data",    32'(hs0),           32'h81);
    check("t6_rx_data",    32'(rx_data),       32'h81);
    check("t6_parity_err", 32'(pe_cnt - pe0),  32'(PE_EXP));

    // Randomized frames with mid-frame baud select changes
    hs_q.delete();
    exp_q.delete();
    exp_fe   = 0;
    fe0      = fe_cnt;
    pe0      = pe_cnt;
    rx_ready = 1'b1;
    for (int n = 0; n < 12; n++) begin
      sel_r  = 2'($urandom_range(1, 3));
      byte_v = 8'($urandom);
      bad    = ($urandom_range(0, 4) == 0);
      send_frame(byte_v, sel_r, bad, 1'b0, 1'b1);
      if (bad) begin
        exp_fe++;
        rx = 1'b1;
        clocks(8 * div_of(sel_r));
      end else begin
        exp_q.push_back(byte_v);
        gap = $urandom_range(0, 2);
        clocks(gap * 8 * div_of(sel_r));
      end
    end
    clocks(8 * div_of(2'd1));
    check("t7_byte_count", 32'(hs_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size(); i++) begin
      hs0 = (i < hs_q.size()) ? hs_q[i] : 8'hxx;
      check($sformatf("t7_byte%0d", i), 32'(hs0), 32'(exp_q[i]));
    end
    check("t7_frame_errs",  32'(fe_cnt - fe0), 32'(exp_fe));
    check("t7_parity_errs", 32'(pe_cnt - pe0), 32'd0);
    check("t7_overrun",     32'(overrun), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_rx_oversample.md
# uart_rx_oversample

UART receiver that sits on the far end of the serial line from the transmit path and turns the `rx` pin into bytes. It generates its own 8x-oversample enable tick from the system clock, using the same baud selection code and divisors as the baud generator. It detects and validates the start bit, then samples each bit at mid-period. Completed bytes go to a single-entry holding register with a valid/ready handshake for the matrix-load controller. All logic runs on `clk`; no derived clocks.

## Interface
- `CLK_FREQ`, 100_000_000: system clock frequency in Hz; divisor = CLK_FREQ / (baud*8), integer truncation.
- `clk` input 1: system clock, all flops rising-edge.
- `reset` input 1: asynchronous, active-low reset (asserted at 0).
- `sel_baud` input 2: baud select; 00=9600, 01=19200, 10=57600, 11=115200. At 100 MHz the divisors are 1302 / 651 / 217 / 108.
- `rx` input 1: asynchronous serial line, idle high.
- `rx_data` output 8: received byte, stable while `rx_valid`=1.
- `rx_valid` output 1: holding register full.
- `rx_ready` input 1: consumer accepts byte when `rx_valid`&&`rx_ready` on a clk edge.
- `frame_err` output 1: one-clk pulse, stop bit sampled low.
- `overrun` output 1: sticky; set when a byte completes while `rx_valid`=1; cleared by the next accepted handshake.
- `parity_err` output 1: one-clk pulse (see Configuration).
- `busy` output 1: high in any state other than IDLE.

## Operation
- `rx` passes through a 2-flop synchronizer. All references to "line" mean the synchronized value.
- Tick generator: 16-bit counter. It pulses `tick` for one clk when counter == divisor-1, then wraps to 0.
  - Counter is forced to 0 on the clk where IDLE detects line=0.
  - `sel_baud` is latched into the divisor register at that same clk. A frame always uses its latched divisor; mid-frame `sel_baud` changes take effect at the next start bit.
- Tick counter `tcnt` is 3 bits and counts ticks within a bit. Bit counter `bcnt` is 3 bits.
- FSM states:
  - IDLE: line=0 → START, with tcnt=0.
  - START: on the 4th tick (mid start bit), sample the line.
    - 0 → DATA, tcnt=0, bcnt=0.
    - 1 → IDLE (glitch rejected, no flag).
  - DATA: on every 8th tick, shift the line into the MSB of the shift register (LSB-first on the wire).
    - When bcnt==7 → PARITY if compiled in, else STOP.
  - PARITY: on the 8th tick, sample the parity bit → STOP.
  - STOP: on the 8th tick, sample the line.
    - 1: byte complete. If `rx_valid`=0, load `rx_data` and set `rx_valid`. Else discard the new byte, keep the old one, set `overrun`. → IDLE.
    - 0: pulse `frame_err`, discard byte → WAIT_HIGH.
  - WAIT_HIGH: line=1 → IDLE. This prevents a break condition from re-triggering start detection.
- Handshake: `rx_valid` clears on the clk after `rx_valid`&&`rx_ready`.
  - If a byte completes on the same clk as the handshake, the new byte loads, `rx_valid` stays 1, and no overrun is flagged.
- Reset (any time, including mid-frame) returns the block to IDLE and clears all counters.
  - Output reset values: `rx_data`=0x00, `rx_valid`=0, `frame_err`=0, `overrun`=0, `parity_err`=0, `busy`=0.

## Timing
- Start detect: 2 clk after the falling edge on `rx` (synchronizer latency).
- Mid-stop sample occurs (4+64+8)=76 ticks after start detect, or 84 ticks with parity. Both figures are measured from the start-detect clk.
- `rx_valid`, `frame_err` and `parity_err` assert on the clk following the tick that samples the stop bit.
- Sample point error ≤ 1 clk relative to the ideal tick-aligned point. Tolerates ±3% baud mismatch.
- Back-to-back frames are supported: STOP→IDLE occurs at mid-stop, so a start edge arriving half a bit later is caught.

## Configuration
- `UART_RX_PARITY_EN` defined:
  - PARITY state included; even parity is expected after bit 7.
  - On mismatch, `parity_err` pulses together with the byte-complete clk. The byte is still delivered.
- Not defined:
  - No PARITY state; the frame is 8N1.
  - `parity_err` is tied to 0.

## Test plan
- sel_baud=11, send 8N1 0xA5 (bit period 864 clk), `rx_ready`=0 → `rx_valid`=1 with `rx_data`=0xA5 at start-detect + 8208 clk + 1; `busy` low at the same clk.
- sel_baud=00, send 0x3C then 0xC3 back-to-back, `rx_ready` held 1 → two handshakes, data 0x3C then 0xC3, `overrun`=0.
- Send 0x11 then 0x22 with `rx_ready`=0 → `rx_data` stays 0x11, `overrun`=1. Pulse `rx_ready` → `rx_valid`=0, `overrun`=0.
- Low glitch of 2 tick periods on idle line → `busy` returns 0 at the 4th tick; no `rx_valid`, no `frame_err`.
- Send 0x55 with the stop bit driven 0, then hold the line low 20 bit periods → exactly one `frame_err` pulse, no `rx_valid`; no new start until the line returns high.
- Assert `reset` (drive 0) mid-DATA of a 0xFF frame, release, then send 0x81 → only 0x81 is received. With `UART_RX_PARITY_EN`, a wrong parity bit on 0x81 → `parity_err` pulse and `rx_data`=0x81.
